// File: rtl/prod_window_accum.sv
// Per-lane window accumulator for the dual product lanes: sums 2^LOG_N products,
// reports sum and mean per lane plus a lane-0 over-threshold count, held until consumed.
module prod_window_accum #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LOG_N  = 4,
    parameter int unsigned ACC_W  = DATA_W + LOG_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] prod,
    input  logic [DATA_W-1:0] prod1,
    input  logic [DATA_W-1:0] thr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic [ACC_W-1:0]  sum1,
    output logic [DATA_W-1:0] mean,
    output logic [DATA_W-1:0] mean1,
    output logic [LOG_N:0]    over_cnt
);

    localparam int unsigned CNT_W  = LOG_N;
    localparam int unsigned OCNT_W = LOG_N + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((2 ** LOG_N) - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t              state;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc1;
    logic [OCNT_W-1:0]   ocnt;
    logic [CNT_W-1:0]    cnt;

    logic [ACC_W-1:0]    acc_c;
    logic [ACC_W-1:0]    acc1_c;
    logic [OCNT_W-1:0]   ocnt_c;

    // Running totals including the beat currently presented
    always_comb begin
        acc_c  = acc + ACC_W'(prod);
        acc1_c = acc1 + ACC_W'(prod1);
        ocnt_c = ocnt + OCNT_W'(prod > thr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            acc1      <= '0;
            ocnt      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            sum1      <= '0;
            mean      <= '0;
            mean1     <= '0;
            over_cnt  <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc  <= acc_c;
                        acc1 <= acc1_c;
                        ocnt <= ocnt_c;
                        cnt  <= cnt + CNT_W'(1);
                        // Final beat of the window: publish results on this edge
                        if (cnt == LAST_CNT) begin
                            sum       <= acc_c;
                            sum1      <= acc1_c;
                            mean      <= DATA_W'(acc_c >> LOG_N);
                            mean1     <= DATA_W'(acc1_c >> LOG_N);
                            over_cnt  <= ocnt_c;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Result registers are left as-is after the handshake
                    if (out_ready) begin
                        acc       <= '0;
                        acc1      <= '0;
                        ocnt      <= '0;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prod_window_accum.sv
// Directed bench for prod_window_accum: window sums/means, threshold count,
// backpressure, input gaps and reset in mid-window and in HOLD.
module tb_prod_window_accum;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] prod;
    logic [63:0] prod1;
    logic [63:0] thr;
    logic        out_valid;
    logic        out_ready;
    logic [67:0] sum;
    logic [67:0] sum1;
    logic [63:0] mean;
    logic [63:0] mean1;
    logic [4:0]  over_cnt;

    int checks;
    int errors;

    prod_window_accum #(
        .DATA_W(64),
        .LOG_N (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .prod     (prod),
        .prod1    (prod1),
        .thr      (thr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .sum1     (sum1),
        .mean     (mean),
        .mean1    (mean1),
        .over_cnt (over_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one cycle of input, then step to just after the rising edge
    task automatic drive(input logic v, input logic [63:0] p, input logic [63:0] p1,
                         input logic [63:0] t);
        in_valid = v;
        prod     = p;
        prod1    = p1;
        thr      = t;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b0, 64'd0, 64'd0, 64'd0);
        drive(1'b0, 64'd0, 64'd0, 64'd0);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
        end
        checks++;
        if (sum !== 68'd0 || sum1 !== 68'd0 || mean !== 64'd0 || mean1 !== 64'd0 || over_cnt !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: sum=%0d sum1=%0d mean=%0d mean1=%0d over=%0d expected all 0",
                     sum, sum1, mean, mean1, over_cnt);
        end
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) drive(1'b1, 64'd1155, 64'd1155, 64'd2000);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: out_valid=%0b expected 0 after 15 beats", out_valid);
        end
        drive(1'b1, 64'd1155, 64'd1155, 64'd2000);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid: out_valid=%0b in_ready=%0b expected 1/0", out_valid, in_ready);
        end
        checks++;
        if (sum !== 68'd18480 || sum1 !== 68'd18480) begin
            errors++;
            $display("FAIL basic_sum: sum=%0d sum1=%0d expected 18480", sum, sum1);
        end
        checks++;
        if (mean !== 64'd1155 || mean1 !== 64'd1155 || over_cnt !== 5'd0) begin
            errors++;
            $display("FAIL basic_mean: mean=%0d mean1=%0d over=%0d expected 1155/1155/0", mean, mean1, over_cnt);
        end
        drive(1'b0, 64'd0, 64'd0, 64'd0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_pulse: out_valid=%0b in_ready=%0b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_wide;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) drive(1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        checks++;
        if (sum1 !== 68'hF_FFFF_FFFF_FFFF_FFF0 || mean1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL wide_lane1: sum1=%h mean1=%h expected fffffffffffffff0/ffffffffffffffff", sum1, mean1);
        end
        checks++;
        if (sum !== 68'd0 || over_cnt !== 5'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wide_lane0: sum=%0d over=%0d valid=%0b expected 0/0/1", sum, over_cnt, out_valid);
        end
        drive(1'b0, 64'd0, 64'd0, 64'd0);
    endtask

    task automatic test_threshold;
        out_ready = 1'b1;
        // Beat 0 is exactly the threshold, then 1001/999 alternate
        for (int i = 0; i < 16; i++) begin
            if (i == 0)          drive(1'b1, 64'd1000, 64'd0, 64'd1000);
            else if (i % 2 == 1) drive(1'b1, 64'd1001, 64'd0, 64'd1000);
            else                 drive(1'b1, 64'd999, 64'd0, 64'd1000);
        end
        checks++;
        if (over_cnt !== 5'd8 || sum !== 68'd16001 || mean !== 64'd1000) begin
            errors++;
            $display("FAIL thr_mixed: over=%0d sum=%0d mean=%0d expected 8/16001/1000", over_cnt, sum, mean);
        end
        drive(1'b0, 64'd0, 64'd0, 64'd0);
        for (int i = 0; i < 16; i++) drive(1'b1, 64'd1001, 64'd0, 64'd1000);
        checks++;
        if (over_cnt !== 5'd16 || sum !== 68'd16016 || mean !== 64'd1001) begin
            errors++;
            $display("FAIL thr_all: over=%0d sum=%0d mean=%0d expected 16/16016/1001", over_cnt, sum, mean);
        end
        drive(1'b0, 64'd0, 64'd0, 64'd0);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) drive(1'b1, 64'(i + 1), 64'd100, 64'd8);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 64'(5000 + k), 64'(7000 + k), 64'd0);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== 68'd136 || sum1 !== 68'd1600
                || mean !== 64'd8 || mean1 !== 64'd100 || over_cnt !== 5'd8) begin
                errors++;
                $display("FAIL bp_hold[%0d]: rdy=%0b vld=%0b sum=%0d sum1=%0d mean=%0d mean1=%0d over=%0d expected 0/1/136/1600/8/100/8",
                         k, in_ready, out_valid, sum, sum1, mean, mean1, over_cnt);
            end
        end
        // Handshake cycle with a live input that must not be taken
        out_ready = 1'b1;
        drive(1'b1, 64'd7777, 64'd7777, 64'd0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%0b in_ready=%0b expected 0/1", out_valid, in_ready);
        end
        for (int i = 0; i < 15; i++) drive(1'b1, 64'd10, 64'd20, 64'd9);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_fresh_early: out_valid=%0b expected 0 after 15 beats", out_valid);
        end
        drive(1'b1, 64'd10, 64'd20, 64'd9);
        checks++;
        if (out_valid !== 1'b1 || sum !== 68'd160 || sum1 !== 68'd320 || over_cnt !== 5'd16) begin
            errors++;
            $display("FAIL bp_fresh: vld=%0b sum=%0d sum1=%0d over=%0d expected 1/160/320/16",
                     out_valid, sum, sum1, over_cnt);
        end
        drive(1'b0, 64'd0, 64'd0, 64'd0);
    endtask

    task automatic test_gaps;
        logic [39:0] gmask;
        int          k;
        int          bad_early;
        gmask     = 40'h96_A5C3_5A69;
        k         = 0;
        bad_early = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && k < 16; c++) begin
            if (gmask[c]) begin
                drive(1'b1, 64'(k * 100), 64'd50000, 64'd700);
                k++;
            end else begin
                drive(1'b0, 64'd999999, 64'd999999, 64'd0);
            end
            if (k < 16 && out_valid !== 1'b0) bad_early++;
        end
        checks++;
        if (k != 16 || bad_early != 0) begin
            errors++;
            $display("FAIL gap_progress: accepted=%0d early_valid=%0d expected 16/0", k, bad_early);
        end
        checks++;
        if (out_valid !== 1'b1 || sum !== 68'd12000 || sum1 !== 68'd800000 || mean !== 64'd750
            || mean1 !== 64'd50000 || over_cnt !== 5'd8) begin
            errors++;
            $display("FAIL gap_result: vld=%0b sum=%0d sum1=%0d mean=%0d mean1=%0d over=%0d expected 1/12000/800000/750/50000/8",
                     out_valid, sum, sum1, mean, mean1, over_cnt);
        end
        drive(1'b0, 64'd0, 64'd0, 64'd0);
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) drive(1'b1, 64'd500, 64'd500, 64'd0);
        rst = 1'b1;
        drive(1'b1, 64'd500, 64'd500, 64'd0);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 68'd0 || mean !== 64'd0 || over_cnt !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid_state: rdy=%0b vld=%0b sum=%0d mean=%0d over=%0d expected 1/0/0/0/0",
                     in_ready, out_valid, sum, mean, over_cnt);
        end
        for (int i = 0; i < 15; i++) drive(1'b1, 64'd2, 64'd3, 64'd1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_early: out_valid=%0b expected 0 after 15 beats", out_valid);
        end
        drive(1'b1, 64'd2, 64'd3, 64'd1);
        checks++;
        if (out_valid !== 1'b1 || sum !== 68'd32 || sum1 !== 68'd48 || mean !== 64'd2 || over_cnt !== 5'd16) begin
            errors++;
            $display("FAIL rst_mid_window: vld=%0b sum=%0d sum1=%0d mean=%0d over=%0d expected 1/32/48/2/16",
                     out_valid, sum, sum1, mean, over_cnt);
        end
        drive(1'b0, 64'd0, 64'd0, 64'd0);
    endtask

    task automatic test_reset_hold;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) drive(1'b1, 64'd4, 64'd4, 64'd0);
        checks++;
        if (out_valid !== 1'b1 || sum !== 68'd64) begin
            errors++;
            $display("FAIL rst_hold_pre: vld=%0b sum=%0d expected 1/64", out_valid, sum);
        end
        out_ready = 1'b1;
        rst = 1'b1;
        drive(1'b0, 64'd0, 64'd0, 64'd0);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 68'd0 || sum1 !== 68'd0 || mean1 !== 64'd0) begin
            errors++;
            $display("FAIL rst_hold_state: vld=%0b rdy=%0b sum=%0d sum1=%0d mean1=%0d expected 0/1/0/0/0",
                     out_valid, in_ready, sum, sum1, mean1);
        end
        for (int i = 0; i < 16; i++) drive(1'b1, 64'd1, 64'd2, 64'd1);
        checks++;
        if (out_valid !== 1'b1 || sum !== 68'd16 || sum1 !== 68'd32 || mean !== 64'd1 || over_cnt !== 5'd0) begin
            errors++;
            $display("FAIL rst_hold_after: vld=%0b sum=%0d sum1=%0d mean=%0d over=%0d expected 1/16/32/1/0",
                     out_valid, sum, sum1, mean, over_cnt);
        end
        drive(1'b0, 64'd0, 64'd0, 64'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        prod      = '0;
        prod1     = '0;
        thr       = '0;
        test_reset();
        test_basic();
        test_wide();
        test_threshold();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_reset_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
